// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: BCD digit type, per-digit
// limits and the split of the minute limit into tens and units.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int DECI_MAX = 9;
  localparam int SEC0_MAX = 9;
  localparam int SEC1_MAX = 5;
  localparam int MIN0_MAX = 9;

  function automatic bcd_t bcd_tens(input int v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t bcd_units(input int v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One enable-chained BCD digit: advances on en, wraps to 0 and raises carry
// on the same cycle when it is enabled at MAX.
module bcd_digit #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] out,
  output logic       carry
);

  assign carry = en && (out == 4'(MAX));

  always_ff @(posedge clk) begin
    if (clr) begin
      out <= '0;
    end else if (carry) begin
      out <= '0;
    end else if (en) begin
      out <= out + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch with tick prescaler, BCD counter chain (tenths..minutes), edge-
// detected start/stop and lap buttons, lap display hold and wrap/saturate.
module stopwatch_lap #(
  parameter int TICK_DIV = 10_000_000,
  parameter int MIN_MAX  = 59,
  parameter int WRAP     = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start_stop,
  input  logic       lap,
  output logic [3:0] deci,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic       running,
  output logic       lap_hold,
  output logic       ovf
);
  import stopwatch_pkg::*;

  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bcd_t           MIN_TENS   = bcd_tens(MIN_MAX);
  localparam bcd_t           MIN_UNITS  = bcd_units(MIN_MAX);
  localparam logic           SATURATE   = (WRAP == 0);

  logic          ss_p1, lap_p1;
  logic          ss_ev, lap_ev;
  logic [PW-1:0] presc;
  logic          running_r, lap_hold_r, ovf_r;

  bcd_t live_deci, live_sec0, live_sec1, live_min0, live_min1;
  bcd_t lap_deci, lap_sec0, lap_sec1, lap_min0, lap_min1;
  logic c_deci, c_sec0, c_sec1, c_min0, c_min1;

  logic sat, tick, full, min_top, adv, ovf_ev, min_en, min_clr, capture;

  // Stage 0: button edges, tick and overflow decode from pre-edge state
  assign ss_ev   = start_stop && !ss_p1;
  assign lap_ev  = lap && !lap_p1;
  assign sat     = SATURATE && ovf_r;
  assign tick    = running_r && !sat && (presc == PRESC_LAST);
  assign min_top = (live_min1 == MIN_TENS) && (live_min0 == MIN_UNITS);
  assign full    = (live_deci == bcd_t'(DECI_MAX)) && (live_sec0 == bcd_t'(SEC0_MAX)) &&
                   (live_sec1 == bcd_t'(SEC1_MAX)) && min_top;
  assign ovf_ev  = tick && full;
  // In saturate mode the overflow tick itself must not disturb the digits.
  assign adv     = tick && !(SATURATE && full);
  assign min_en  = c_sec1 && !min_top;
  // A tens rollover is unreachable for legal minute values; treating it as a
  // wrap keeps the minute pair bounded no matter what.
  assign min_clr = clr || (ovf_ev && !SATURATE) || c_min1;
  assign capture = lap_ev && !lap_hold_r && running_r;

  always_ff @(posedge clk) begin
    if (clr) begin
      ss_p1      <= 1'b0;
      lap_p1     <= 1'b0;
      presc      <= '0;
      running_r  <= 1'b0;
      lap_hold_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      ss_p1  <= start_stop;
      lap_p1 <= lap;
      if (running_r && !sat) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      if (ovf_ev) begin
        ovf_r <= 1'b1;
      end
      if (ovf_ev && SATURATE) begin
        running_r <= 1'b0;
      end else begin
        running_r <= running_r ^ ss_ev;
      end
      if (lap_ev) begin
        if (lap_hold_r) begin
          lap_hold_r <= 1'b0;
        end else if (running_r) begin
          lap_hold_r <= 1'b1;
        end
      end
    end
  end

  // Stage 1: counter chain, every carry resolved within the tick edge
  bcd_digit #(.MAX(DECI_MAX)) u_deci (
    .clk(clk), .clr(clr), .en(adv), .out(live_deci), .carry(c_deci)
  );
  bcd_digit #(.MAX(SEC0_MAX)) u_sec0 (
    .clk(clk), .clr(clr), .en(c_deci), .out(live_sec0), .carry(c_sec0)
  );
  bcd_digit #(.MAX(SEC1_MAX)) u_sec1 (
    .clk(clk), .clr(clr), .en(c_sec0), .out(live_sec1), .carry(c_sec1)
  );
  bcd_digit #(.MAX(MIN0_MAX)) u_min0 (
    .clk(clk), .clr(min_clr), .en(min_en), .out(live_min0), .carry(c_min0)
  );
  bcd_digit #(.MAX(int'(MIN_TENS))) u_min1 (
    .clk(clk), .clr(min_clr), .en(c_min0), .out(live_min1), .carry(c_min1)
  );

  // Stage 1: lap registers hold pre-tick live digits; only shown while held
  always_ff @(posedge clk) begin
    if (capture) begin
      lap_deci <= live_deci;
      lap_sec0 <= live_sec0;
      lap_sec1 <= live_sec1;
      lap_min0 <= live_min0;
      lap_min1 <= live_min1;
    end
  end

  // Stage 2: display mux straight off registers
  assign deci     = lap_hold_r ? lap_deci : live_deci;
  assign sec0     = lap_hold_r ? lap_sec0 : live_sec0;
  assign sec1     = lap_hold_r ? lap_sec1 : live_sec1;
  assign min0     = lap_hold_r ? lap_min0 : live_min0;
  assign min1     = lap_hold_r ? lap_min1 : live_min1;
  assign running  = running_r;
  assign lap_hold = lap_hold_r;
  assign ovf      = ovf_r;

endmodule
